timer_countdown_sequencer: RTL and testbench

Sequences the countdown datapath of the MM:SS kitchen timer. It captures the BCD time produced by the switch-setting path and generates the one-second decrement tick. It decrements minutes and seconds in BCD with borrow, reports when the count reaches 00:00, and drives the LEDR flash pattern. It sits between the timer state-machine controller (which supplies `load`, `dec_en`, `flash_en`) and the HEX/LEDR display path.

---
 rtl/timer_countdown_sequencer.sv | 166 ++++++++++++++++
 tb/tb_timer_countdown_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_countdown_sequencer.sv
// rtl/timer_countdown_sequencer.sv - MM:SS countdown datapath: BCD load/clamp, 1 s prescaler, borrow decrement, LEDR flash
module timer_countdown_sequencer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int FLASH_DIV     = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       dec_en,
  input  logic       flash_en,
  output logic [7:0] min_out,
  output logic [7:0] sec_out,
  output logic       tick,
  output logic       time_flat,
  output logic [9:0] ledr,
  output logic [1:0] state
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [FW-1:0] FMAX = FW'(FLASH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        st, st_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [7:0]    min_r, sec_r, min_nxt, sec_nxt;
  logic          tick_nxt;
  logic [15:0]   dec_val;

  logic          flash_on;
  logic [FW-1:0] fcnt;
  logic [9:0]    ledr_r;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // {min, sec} minus one second with cascaded BCD borrow; caller never passes 00:00
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] m_t, m_o, s_t, s_o;
    {m_t, m_o, s_t, s_o} = t;
    if (s_o != 4'd0) begin
      s_o = s_o - 4'd1;
    end else begin
      s_o = 4'd9;
      if (s_t != 4'd0) begin
        s_t = s_t - 4'd1;
      end else begin
        s_t = 4'd5;
        if (m_o != 4'd0) begin
          m_o = m_o - 4'd1;
        end else begin
          m_o = 4'd9;
          m_t = m_t - 4'd1;
        end
      end
    end
    return {m_t, m_o, s_t, s_o};
  endfunction

  assign time_flat = (min_r == 8'h00) && (sec_r == 8'h00);
  assign dec_val   = bcd_dec({min_r, sec_r});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= IDLE;
      presc <= '0;
      min_r <= 8'h00;
      sec_r <= 8'h00;
      tick  <= 1'b0;
    end else begin
      st    <= st_nxt;
      presc <= presc_nxt;
      min_r <= min_nxt;
      sec_r <= sec_nxt;
      tick  <= tick_nxt;
    end
  end

  always_comb begin
    st_nxt    = st;
    presc_nxt = presc;
    min_nxt   = min_r;
    sec_nxt   = sec_r;
    tick_nxt  = 1'b0;
    if (load) begin
      min_nxt   = {clamp_digit(load_min[7:4], 4'd9), clamp_digit(load_min[3:0], 4'd9)};
      sec_nxt   = {clamp_digit(load_sec[7:4], 4'd5), clamp_digit(load_sec[3:0], 4'd9)};
      presc_nxt = '0;
      st_nxt    = IDLE;
    end else begin
      case (st)
        IDLE: begin
          if (dec_en) begin
            if (time_flat) begin
              st_nxt = EXPIRED;
            end else begin
              st_nxt    = RUN;
              presc_nxt = '0;
            end
          end
        end
        RUN: begin
          // dropping dec_en freezes the prescaler, even on the wrap cycle
          if (!dec_en) begin
            st_nxt = PAUSE;
          end else if (presc == PMAX) begin
            presc_nxt = '0;
            if (time_flat) begin
              st_nxt = EXPIRED;
            end else begin
              {min_nxt, sec_nxt} = dec_val;
              tick_nxt           = 1'b1;
              if (dec_val == 16'h0000) st_nxt = EXPIRED;
            end
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
        PAUSE: begin
          if (dec_en) st_nxt = RUN;
        end
        EXPIRED: begin
          st_nxt = EXPIRED;
        end
      endcase
    end
  end

  // flash_on marks the first enabled edge so the pattern always starts lit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flash_on <= 1'b0;
      fcnt     <= '0;
      ledr_r   <= 10'h000;
    end else if (!flash_en) begin
      flash_on <= 1'b0;
      fcnt     <= '0;
      ledr_r   <= 10'h000;
    end else if (!flash_on) begin
      flash_on <= 1'b1;
      fcnt     <= '0;
      ledr_r   <= 10'h3FF;
    end else if (fcnt == FMAX) begin
      fcnt   <= '0;
      ledr_r <= ~ledr_r;
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end

  assign min_out = min_r;
  assign sec_out = sec_r;
  assign ledr    = ledr_r;
  assign state   = st;

endmodule

// File: tb/tb_timer_countdown_sequencer.sv
// tb/tb_timer_countdown_sequencer.sv - self-checking bench for timer_countdown_sequencer
module tb_timer_countdown_sequencer;
  localparam int T = 4;
  localparam int F = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_min = 8'h00;
  logic [7:0] load_sec = 8'h00;
  logic       dec_en = 1'b0;
  logic       flash_en = 1'b0;
  logic [7:0] min_out, sec_out;
  logic       tick, time_flat;
  logic [9:0] ledr;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: time kept as total seconds, flash as cycles since enable
  int m_t, m_st, m_prog, m_fk;
  bit m_tick, m_fon;

  typedef struct {
    logic [7:0] lm;
    logic [7:0] ls;
    logic [7:0] exp_min;
    logic [7:0] exp_sec;
    logic       exp_flat;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  timer_countdown_sequencer #(.TICKS_PER_SEC(T), .FLASH_DIV(F)) dut (
    .clk(clk), .reset(reset), .load(load), .load_min(load_min), .load_sec(load_sec),
    .dec_en(dec_en), .flash_en(flash_en), .min_out(min_out), .sec_out(sec_out),
    .tick(tick), .time_flat(time_flat), .ledr(ledr), .state(state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int min4(input int a, input int b);
    return (a > b) ? b : a;
  endfunction

  function automatic int clamp_time(input logic [7:0] lm, input logic [7:0] ls);
    int mins, secs;
    mins = min4(int'(lm[7:4]), 9) * 10 + min4(int'(lm[3:0]), 9);
    secs = min4(int'(ls[7:4]), 5) * 10 + min4(int'(ls[3:0]), 9);
    return mins * 60 + secs;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic model_reset();
    m_t = 0; m_st = 0; m_prog = 0; m_tick = 0; m_fon = 0; m_fk = 0;
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
    end else begin
      m_tick = 0;
      if (load) begin
        m_t = clamp_time(load_min, load_sec);
        m_st = 0;
        m_prog = 0;
      end else begin
        case (m_st)
          0: if (dec_en) begin
               if (m_t == 0) m_st = 3;
               else begin m_st = 1; m_prog = 0; end
             end
          1: if (!dec_en) m_st = 2;
             else if (m_prog == T - 1) begin
               m_prog = 0;
               m_t = m_t - 1;
               m_tick = 1;
               if (m_t == 0) m_st = 3;
             end else m_prog++;
          2: if (dec_en) m_st = 1;
          default: ;
        endcase
      end
      if (flash_en) begin
        if (m_fon) m_fk++;
        else begin m_fon = 1; m_fk = 0; end
      end else m_fon = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_all(input string p);
    logic [9:0] exp_ledr;
    exp_ledr = (m_fon && ((m_fk / F) % 2 == 0)) ? 10'h3FF : 10'h000;
    chk({p, "_min"}, 32'(min_out), 32'(to_bcd(m_t / 60)));
    chk({p, "_sec"}, 32'(sec_out), 32'(to_bcd(m_t % 60)));
    chk({p, "_tick"}, 32'(tick), 32'(m_tick));
    chk({p, "_flat"}, 32'(time_flat), 32'(m_t == 0));
    chk({p, "_state"}, 32'(state), 32'(m_st));
    chk({p, "_ledr"}, 32'(ledr), 32'(exp_ledr));
  endtask

  task automatic do_load(input logic [7:0] lm, input logic [7:0] ls);
    load = 1'b1; load_min = lm; load_sec = ls;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hAF, 8'h7C, 8'h99, 8'h59, 1'b0};
    vecs[1] = '{8'h01, 8'h00, 8'h01, 8'h00, 1'b0};
    vecs[2] = '{8'h5A, 8'h60, 8'h59, 8'h50, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h99, 8'h59, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[5] = '{8'h39, 8'h5F, 8'h39, 8'h59, 1'b0};
    model_reset();

    // reset state, during and after release
    #12;
    chk("rst_min", 32'(min_out), 32'h00);
    chk("rst_sec", 32'(sec_out), 32'h00);
    chk("rst_flat", 32'(time_flat), 32'h1);
    chk("rst_ledr", 32'(ledr), 32'h000);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc();
    check_all("rel");

    // load clamping table
    foreach (vecs[i]) begin
      do_load(vecs[i].lm, vecs[i].ls);
      chk("tbl_min", 32'(min_out), 32'(vecs[i].exp_min));
      chk("tbl_sec", 32'(sec_out), 32'(vecs[i].exp_sec));
      chk("tbl_flat", 32'(time_flat), 32'(vecs[i].exp_flat));
      chk("tbl_state", 32'(state), 32'h0);
    end

    // 01:00 -> 00:59 -> 00:58
    do_load(8'h01, 8'h00);
    dec_en = 1'b1;
    cyc();
    chk("t2_state", 32'(state), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("t2_min", 32'(min_out), (i < 4) ? 32'h01 : 32'h00);
      chk("t2_sec", 32'(sec_out), (i < 4) ? 32'h00 : (i < 8) ? 32'h59 : 32'h58);
      chk("t2_tick", 32'(tick), (i == 4 || i == 8) ? 32'h1 : 32'h0);
    end

    // 00:02 runs out and stays expired
    do_load(8'h00, 8'h02);
    cyc();
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 4) chk("t3_sec1", 32'(sec_out), 32'h01);
    end
    chk("t3_sec0", 32'(sec_out), 32'h00);
    chk("t3_flat", 32'(time_flat), 32'h1);
    chk("t3_state", 32'(state), 32'h3);
    chk("t3_tick", 32'(tick), 32'h1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t3_hold_tick", 32'(tick), 32'h0);
      chk("t3_hold_sec", 32'(sec_out), 32'h00);
      chk("t3_hold_state", 32'(state), 32'h3);
    end

    // pause does not count toward the period
    do_load(8'h00, 8'h10);
    cyc();
    chk("t4_run", 32'(state), 32'h1);
    cyc(); cyc();
    dec_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t4_pause", 32'(state), 32'h2);
    end
    chk("t4_psec", 32'(sec_out), 32'h10);
    dec_en = 1'b1;
    cyc();
    chk("t4_resume", 32'(state), 32'h1);
    chk("t4_r0_tick", 32'(tick), 32'h0);
    cyc();
    chk("t4_r1_sec", 32'(sec_out), 32'h10);
    cyc();
    chk("t4_r2_sec", 32'(sec_out), 32'h09);
    chk("t4_r2_tick", 32'(tick), 32'h1);

    // load coinciding with a prescaler wrap
    do_load(8'h05, 8'h30);
    cyc(); cyc(); cyc(); cyc();
    do_load(8'h05, 8'h30);
    chk("t5_min", 32'(min_out), 32'h05);
    chk("t5_sec", 32'(sec_out), 32'h30);
    chk("t5_tick", 32'(tick), 32'h0);
    chk("t5_state", 32'(state), 32'h0);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("t5_sec_run", 32'(sec_out), (i < 4) ? 32'h30 : 32'h29);
    end

    // dec_en falling on the wrap cycle
    do_load(8'h00, 8'h05);
    cyc(); cyc(); cyc(); cyc();
    dec_en = 1'b0;
    cyc();
    chk("t6_state", 32'(state), 32'h2);
    chk("t6_sec", 32'(sec_out), 32'h05);
    chk("t6_tick", 32'(tick), 32'h0);
    dec_en = 1'b1;
    cyc();
    chk("t6_resume_sec", 32'(sec_out), 32'h05);
    cyc();
    chk("t6_dec_sec", 32'(sec_out), 32'h04);
    chk("t6_dec_tick", 32'(tick), 32'h1);
    dec_en = 1'b0;

    // flash pattern, disable, and async reset mid-phase
    flash_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("fl_ledr", 32'(ledr), ((i / 2) % 2 == 1) ? 32'h000 : 32'h3FF);
    end
    flash_en = 1'b0;
    cyc();
    chk("fl_off", 32'(ledr), 32'h000);
    flash_en = 1'b1;
    cyc(); cyc();
    #2 reset = 1'b0;
    #1;
    chk("ar_ledr", 32'(ledr), 32'h000);
    chk("ar_sec", 32'(sec_out), 32'h00);
    chk("ar_state", 32'(state), 32'h0);
    chk("ar_flat", 32'(time_flat), 32'h1);
    flash_en = 1'b0;
    cyc();
    reset = 1'b1;
    check_all("ar_hold");

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      load = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) begin
        load_min = 8'h00;
        load_sec = 8'($urandom_range(0, 3));
      end else begin
        load_min = 8'($urandom);
        load_sec = 8'($urandom);
      end
      if ($urandom_range(0, 9) == 0) dec_en = ~dec_en;
      if ($urandom_range(0, 14) == 0) flash_en = ~flash_en;
      cyc();
      check_all("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
